vga_timing_rx: RTL and testbench
================================

# vga_timing_rx

Receive side of the team's 640x480@60 VGA link: samples incoming hsync/vsync/16-bit RGB565 produced by the VGA timing generator, measures line and frame timing, locks when timing matches the nominal mode, and re-emits pixels with recovered coordinates. Sits between the video input pins (or loopback from the generator) and downstream capture/frame-buffer logic.

## Interface
- H_SYNC, 96, hsync pulse width in clocks
- H_START, 144, clocks from hsync rise to first active pixel (sync+back+left border)
- H_VALID, 640, active pixels per line
- H_TOTAL, 800, clocks per line
- V_SYNC, 2, vsync pulse width in lines
- V_START, 35, lines from vsync rise to first active line
- V_VALID, 480, active lines per frame
- V_TOTAL, 525, lines per frame

- vga_clk  in  1  pixel clock; single clock domain
- sys_rst  in  1  synchronous, active-high reset
- hsync  in  1  horizontal sync, active high
- vsync  in  1  vertical sync, active high
- rgb  in  16  pixel data, RGB565
- pix_x  out  10  active column 0..639; 10'h3FF when pix_valid low
- pix_y  out  10  active row 0..479; 10'h3FF when pix_valid low
- pix_data  out  16  registered rgb; 0 when pix_valid low
- pix_valid  out  1  active pixel present, only while locked
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0)
- locked  out  1  timing matches parameters
- sync_err  out  1  one-cycle pulse on any timing violation

## Operation
- Stage 1 registers hsync/vsync/rgb; stage 2 holds previous sync for rising-edge detect (hs_rise = hs1 & ~hs2, same for vsync).
- h_cnt (11 bit): 0 on hs_rise, else +1, saturating at 2047. hs_w counts stage-1 high samples after rise.
- v_cnt (10 bit): 0 on vs_rise, +1 on each other hs_rise. vs_w counts lines with vsync high.
- Line check at hs_rise: previous h_cnt == H_TOTAL-1 and hs_w == H_SYNC. Frame check at vs_rise: previous v_cnt == V_TOTAL-1 and vs_w == V_SYNC. Simultaneous hs_rise and vs_rise is the normal frame start; both checks apply.
- Timeout: h_cnt reaching H_TOTAL without hs_rise is a line failure.
- FSM: SEARCH -> MEASURE on first vs_rise. MEASURE -> LOCKED at next vs_rise if every line and the frame check passed; else stay MEASURE, restart. LOCKED -> SEARCH on any failed check or timeout, sync_err pulses that cycle. Failures in SEARCH/MEASURE do not pulse sync_err.
- Active window: LOCKED and H_START <= h_cnt < H_START+H_VALID and V_START <= v_cnt < V_START+V_VALID; pix_x = h_cnt-H_START, pix_y = v_cnt-V_START.
- Reset: FSM SEARCH, counters 0, locked/pix_valid/frame_start/sync_err 0, pix_x/pix_y 10'h3FF, pix_data 0. Reset mid-frame discards measurement; relock needs one full clean frame after the next vs_rise.

## Timing
- Outputs registered; pin-to-output latency 2 vga_clk cycles: pixel sampled on pins at cycle n appears on pix_data at n+2 with its coordinates.
- locked rises the cycle after the vs_rise completing the clean measured frame; frame_start/pixel (0,0) of that same frame is output while locked.
- locked falls the cycle after the failing check; pix_valid drops in the same cycle.
- Throughput: one pixel per clock, no backpressure.

## Structure
- Package vga_timing_pkg: H_*/V_* mode constants (shared with the timing generator), FSM state enum {SEARCH, MEASURE, LOCKED}.
- Sub-module vga_sync_sampler: input register stage plus hsync/vsync rising-edge detect; remainder (counters, checks, FSM, output stage) in vga_timing_rx.

## Test plan
- Reset, then 3 nominal frames from generator model -> locked rises at start of frame 2; 307200 pix_valid per locked frame; frame_start once per frame at (0,0); pix_data equals driven rgb pattern at x+y*640.
- Locked, one line of 799 clocks -> sync_err pulse at that hs_rise, locked 0, pix_valid 0; clean frames -> relock after one full measured frame.
- Locked, hsync held low -> timeout at h_cnt 800, sync_err, locked 0.
- vsync width 3 lines in MEASURE -> no lock, no sync_err; stays MEASURE until a clean frame.
- sys_rst asserted at line 200 of a locked frame -> all outputs reset values next cycle; relock at start of second subsequent frame.
- Border pixels: check (639,479) last valid, h_cnt 784 and v_cnt 515 -> pix_valid 0, pix_x/pix_y 10'h3FF.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 mode constants and receiver lock-state encoding.
package vga_timing_pkg;

   localparam int unsigned H_SYNC  = 96;
   localparam int unsigned H_START = 144;
   localparam int unsigned H_VALID = 640;
   localparam int unsigned H_TOTAL = 800;
   localparam int unsigned V_SYNC  = 2;
   localparam int unsigned V_START = 35;
   localparam int unsigned V_VALID = 480;
   localparam int unsigned V_TOTAL = 525;

   typedef enum logic [1:0] {
      SEARCH,
      MEASURE,
      LOCKED
   } vga_state_e;

endpackage

// File: rtl/vga_sync_sampler.sv
// Input register stage for the VGA receiver plus hsync/vsync rising-edge detect.
module vga_sync_sampler (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [15:0] rgb,
   output logic        hs1,
   output logic        vs1,
   output logic [15:0] rgb1,
   output logic        hs_rise,
   output logic        vs_rise
);

   logic hs2;
   logic vs2;

   always_ff @(posedge clk) begin
      if (rst) begin
         hs1  <= 1'b0;
         vs1  <= 1'b0;
         rgb1 <= '0;
         hs2  <= 1'b0;
         vs2  <= 1'b0;
      end else begin
         hs1  <= hsync;
         vs1  <= vsync;
         rgb1 <= rgb;
         hs2  <= hs1;
         vs2  <= vs1;
      end
   end

   assign hs_rise = hs1 & ~hs2;
   assign vs_rise = vs1 & ~vs2;

endmodule

// File: rtl/vga_timing_rx.sv
// VGA receiver: measures line/frame timing, locks on the nominal mode and
// re-emits pixels with recovered coordinates two clocks after the pins.
module vga_timing_rx
   import vga_timing_pkg::*;
#(
   parameter int unsigned HSync  = H_SYNC,
   parameter int unsigned HStart = H_START,
   parameter int unsigned HValid = H_VALID,
   parameter int unsigned HTotal = H_TOTAL,
   parameter int unsigned VSync  = V_SYNC,
   parameter int unsigned VStart = V_START,
   parameter int unsigned VValid = V_VALID,
   parameter int unsigned VTotal = V_TOTAL
) (
   input  logic        vga_clk,
   input  logic        sys_rst,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [15:0] rgb,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [15:0] pix_data,
   output logic        pix_valid,
   output logic        frame_start,
   output logic        locked,
   output logic        sync_err
);

   localparam logic [10:0] HLast   = 11'(HTotal - 1);
   localparam logic [10:0] HTot    = 11'(HTotal);
   localparam logic [10:0] HSyncL  = 11'(HSync);
   localparam logic [10:0] HStartL = 11'(HStart);
   localparam logic [10:0] HEnd    = 11'(HStart + HValid);
   localparam logic [9:0]  VLast   = 10'(VTotal - 1);
   localparam logic [9:0]  VSyncL  = 10'(VSync);
   localparam logic [9:0]  VStartL = 10'(VStart);
   localparam logic [9:0]  VEnd    = 10'(VStart + VValid);

   logic        hs1, vs1, hs_rise, vs_rise;
   logic [15:0] rgb1;

   vga_sync_sampler u_sampler (
      .clk     (vga_clk),
      .rst     (sys_rst),
      .hsync   (hsync),
      .vsync   (vsync),
      .rgb     (rgb),
      .hs1     (hs1),
      .vs1     (vs1),
      .rgb1    (rgb1),
      .hs_rise (hs_rise),
      .vs_rise (vs_rise)
   );

   logic [10:0] h_cnt_q, h_cnt_d, hs_w_q, hs_w_d;
   logic [9:0]  v_cnt_q, v_cnt_d, vs_w_q, vs_w_d;
   vga_state_e  state_q, state_d;
   logic        meas_ok_q, meas_ok_d;
   logic        line_bad, frame_bad, timeout, fail, err_d;
   logic        in_win;
   logic [9:0]  x_d, y_d;

   // The _d counters describe the sample currently in stage 1, so they are
   // also the coordinates of the pixel being loaded into the output stage.
   always_comb begin
      h_cnt_d = hs_rise ? 11'd0 : ((h_cnt_q == 11'h7FF) ? h_cnt_q : h_cnt_q + 11'd1);
      hs_w_d  = hs_w_q;
      if (hs_rise) begin
         hs_w_d = 11'd1;
      end else if (hs1 && hs_w_q != 11'h7FF) begin
         hs_w_d = hs_w_q + 11'd1;
      end
      v_cnt_d = v_cnt_q;
      vs_w_d  = vs_w_q;
      if (vs_rise) begin
         v_cnt_d = 10'd0;
         vs_w_d  = 10'd1;
      end else if (hs_rise) begin
         if (v_cnt_q != 10'h3FF) v_cnt_d = v_cnt_q + 10'd1;
         if (vs1 && vs_w_q != 10'h3FF) vs_w_d = vs_w_q + 10'd1;
      end
   end

   always_comb begin
      line_bad  = hs_rise && (h_cnt_q != HLast || hs_w_q != HSyncL);
      frame_bad = vs_rise && (v_cnt_q != VLast || vs_w_q != VSyncL);
      timeout   = (h_cnt_d == HTot);
      fail      = line_bad | frame_bad | timeout;
   end

   always_comb begin
      state_d   = state_q;
      meas_ok_d = meas_ok_q;
      err_d     = 1'b0;
      case (state_q)
         SEARCH: begin
            if (vs_rise) begin
               state_d   = MEASURE;
               meas_ok_d = 1'b1;
            end
         end
         MEASURE: begin
            if (vs_rise) begin
               if (meas_ok_q && !fail) begin
                  state_d = LOCKED;
               end
               meas_ok_d = 1'b1;
            end else if (fail) begin
               meas_ok_d = 1'b0;
            end
         end
         LOCKED: begin
            if (fail) begin
               state_d = SEARCH;
               err_d   = 1'b1;
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   always_comb begin
      in_win = (state_d == LOCKED) && (h_cnt_d >= HStartL) && (h_cnt_d < HEnd) &&
               (v_cnt_d >= VStartL) && (v_cnt_d < VEnd);
      x_d    = 10'(h_cnt_d - HStartL);
      y_d    = v_cnt_d - VStartL;
   end

   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         h_cnt_q     <= '0;
         hs_w_q      <= '0;
         v_cnt_q     <= '0;
         vs_w_q      <= '0;
         state_q     <= SEARCH;
         meas_ok_q   <= 1'b0;
         pix_x       <= 10'h3FF;
         pix_y       <= 10'h3FF;
         pix_data    <= '0;
         pix_valid   <= 1'b0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         hs_w_q      <= hs_w_d;
         v_cnt_q     <= v_cnt_d;
         vs_w_q      <= vs_w_d;
         state_q     <= state_d;
         meas_ok_q   <= meas_ok_d;
         pix_x       <= in_win ? x_d : 10'h3FF;
         pix_y       <= in_win ? y_d : 10'h3FF;
         pix_data    <= in_win ? rgb1 : 16'h0000;
         pix_valid   <= in_win;
         frame_start <= in_win && (x_d == 10'd0) && (y_d == 10'd0);
         locked      <= (state_d == LOCKED);
         sync_err    <= err_d;
      end
   end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Randomized bench for vga_timing_rx using a reduced video mode and a
// line/frame-level reference model with a two-sample output latency.
module tb_vga_timing_rx;

   localparam int H_SYNC  = 4;
   localparam int H_START = 10;
   localparam int H_VALID = 16;
   localparam int H_TOTAL = 32;
   localparam int V_SYNC  = 2;
   localparam int V_START = 3;
   localparam int V_VALID = 6;
   localparam int V_TOTAL = 12;

   localparam int M_SEARCH  = 0;
   localparam int M_MEASURE = 1;
   localparam int M_LOCKED  = 2;

   logic        vga_clk = 1'b0;
   logic        sys_rst, hsync, vsync;
   logic [15:0] rgb;
   logic [9:0]  pix_x, pix_y;
   logic [15:0] pix_data;
   logic        pix_valid, frame_start, locked, sync_err;

   vga_timing_rx #(
      .HSync  (H_SYNC),
      .HStart (H_START),
      .HValid (H_VALID),
      .HTotal (H_TOTAL),
      .VSync  (V_SYNC),
      .VStart (V_START),
      .VValid (V_VALID),
      .VTotal (V_TOTAL)
   ) dut (
      .vga_clk     (vga_clk),
      .sys_rst     (sys_rst),
      .hsync       (hsync),
      .vsync       (vsync),
      .rgb         (rgb),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .frame_start (frame_start),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct packed {
      logic        valid;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [15:0] data;
      logic        fs;
      logic        lk;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_bad = 0;
   int   n_valid = 0;
   int   n_fs = 0;
   int   n_err = 0;

   // Model state: lock phase plus the shape of the last line/frame driven.
   int   mst = M_SEARCH;
   bit   m_ok = 1'b0;
   int   prev_len = -1;
   int   prev_hsw = -1;
   int   prev_lines = -1;
   int   prev_vsw = -1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 20) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t reset_exp();
      exp_t e;
      e.valid = 1'b0;
      e.x     = 10'h3FF;
      e.y     = 10'h3FF;
      e.data  = 16'h0000;
      e.fs    = 1'b0;
      e.lk    = 1'b0;
      e.err   = 1'b0;
      return e;
   endfunction

   // Outputs are read 1 time unit after the edge; the sample driven two
   // steps earlier is the one due at the output.
   task automatic tick();
      exp_t e;
      @(posedge vga_clk);
      #1;
      if (exp_q.size() >= 2) begin
         e = exp_q.pop_front();
         check("locked", 32'(locked), 32'(e.lk));
         check("pix_valid", 32'(pix_valid), 32'(e.valid));
         check("pix_x", 32'(pix_x), 32'(e.x));
         check("pix_y", 32'(pix_y), 32'(e.y));
         check("pix_data", 32'(pix_data), 32'(e.data));
         check("frame_start", 32'(frame_start), 32'(e.fs));
         check("sync_err", 32'(sync_err), 32'(e.err));
         n_valid += int'(pix_valid);
         n_fs    += int'(frame_start);
         n_err   += int'(sync_err);
      end
   endtask

   task automatic drive_sample(input int o, input int l, input bit hs, input bit vs,
                               input bit hsr, input bit vsr, input bit rst_now);
      exp_t        e;
      bit          fail;
      logic [15:0] d;
      tick();
      d       = 16'($urandom);
      sys_rst = rst_now;
      hsync   = hs;
      vsync   = vs;
      rgb     = d;
      if (rst_now) begin
         // Both the sample in flight and this one are discarded by the reset.
         e = reset_exp();
         if (exp_q.size() > 0) exp_q[exp_q.size()-1] = e;
         exp_q.push_back(e);
         mst        = M_SEARCH;
         prev_len   = -1;
         prev_lines = -1;
         return;
      end
      fail = 1'b0;
      if (hsr && (prev_len != H_TOTAL || prev_hsw != H_SYNC)) fail = 1'b1;
      if (vsr && (prev_lines != V_TOTAL || prev_vsw != V_SYNC)) fail = 1'b1;
      if (!hsr && o == H_TOTAL) fail = 1'b1;
      e.err = 1'b0;
      if (mst == M_SEARCH) begin
         if (vsr) begin
            mst  = M_MEASURE;
            m_ok = 1'b1;
         end
      end else if (mst == M_MEASURE) begin
         if (vsr) begin
            if (m_ok && !fail) mst = M_LOCKED;
            m_ok = 1'b1;
         end else if (fail) begin
            m_ok = 1'b0;
         end
      end else if (fail) begin
         mst   = M_SEARCH;
         e.err = 1'b1;
      end
      e.lk    = (mst == M_LOCKED);
      e.valid = e.lk && o >= H_START && o < H_START + H_VALID &&
                l >= V_START && l < V_START + V_VALID;
      e.x     = e.valid ? 10'(o - H_START) : 10'h3FF;
      e.y     = e.valid ? 10'(l - V_START) : 10'h3FF;
      e.data  = e.valid ? d : 16'h0000;
      e.fs    = e.valid && o == H_START && l == V_START;
      exp_q.push_back(e);
   endtask

   task automatic drive_line(input int len, input int hsw, input bit vs_high, input int l,
                             input int rst_col);
      for (int o = 0; o < len; o++) begin
         drive_sample(o, l, o < hsw, vs_high, o == 0, o == 0 && l == 0, o == rst_col);
      end
      prev_len = len;
      prev_hsw = hsw;
   endtask

   task automatic drive_frame(input int vsw, input int bad_line, input int bad_len,
                              input int rst_line, input bit rnd);
      int len, hsw;
      for (int l = 0; l < V_TOTAL; l++) begin
         len = (l == bad_line) ? bad_len : H_TOTAL;
         hsw = H_SYNC;
         if (rnd && $urandom_range(0, 15) == 0) len = H_TOTAL + ($urandom_range(0, 1) ? 1 : -1);
         if (rnd && $urandom_range(0, 23) == 0) hsw = H_SYNC + 1;
         drive_line(len, hsw, l < vsw, l, (l == rst_line) ? 15 : -1);
      end
      prev_lines = V_TOTAL;
      prev_vsw   = vsw;
   endtask

   initial begin
      sys_rst = 1'b1;
      hsync   = 1'b0;
      vsync   = 1'b0;
      rgb     = '0;
      repeat (4) tick();
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_valid", 32'(pix_valid), 32'd0);
      check("rst_x", 32'(pix_x), 32'h3FF);
      check("rst_y", 32'(pix_y), 32'h3FF);
      check("rst_data", 32'(pix_data), 32'd0);
      check("rst_fs", 32'(frame_start), 32'd0);
      check("rst_err", 32'(sync_err), 32'd0);
      sys_rst = 1'b0;

      // Nominal: measure frame 1, locked for frames 2 and 3.
      repeat (3) drive_frame(V_SYNC, -1, 0, -1, 1'b0);
      check("nominal_valid_cnt", 32'(n_valid), 32'(2 * H_VALID * V_VALID));
      check("nominal_fs_cnt", 32'(n_fs), 32'd2);
      check("nominal_err_cnt", 32'(n_err), 32'd0);

      n_err = 0;
      drive_frame(V_SYNC, 6, H_TOTAL - 1, -1, 1'b0);   // short line while locked
      drive_frame(V_SYNC, -1, 0, -1, 1'b0);
      drive_frame(V_SYNC, -1, 0, -1, 1'b0);            // relocked at its start
      drive_frame(V_SYNC, 5, H_TOTAL + 20, -1, 1'b0);  // hsync held low -> timeout
      drive_frame(3, -1, 0, -1, 1'b0);                 // wide vsync while measuring
      drive_frame(V_SYNC, -1, 0, -1, 1'b0);
      drive_frame(V_SYNC, -1, 0, 4, 1'b0);             // reset mid-frame while locked
      drive_frame(V_SYNC, -1, 0, -1, 1'b0);
      drive_frame(V_SYNC, -1, 0, -1, 1'b0);
      check("fault_err_cnt", 32'(n_err), 32'd2);
      check("relock_after_reset", 32'(locked), 32'd1);

      repeat (5) drive_frame(($urandom_range(0, 7) == 0) ? 3 : V_SYNC, -1, 0, -1, 1'b1);

      hsync = 1'b0;
      vsync = 1'b0;
      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
